// File: rtl/rng_stream_ctrl.sv
// Command-driven scheduler between the LFSR word source and the UART transmitter.
// Optional status command is compiled in with `define RNG_STREAM_STATUS_EN.
module rng_stream_ctrl #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter bit          DEFAULT_RUN = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       word_valid,
    input  logic [7:0] word,
    input  logic       rx_received,
    input  logic [7:0] rx_byte,
    input  logic       tx_free,
    output logic       transmit,
    output logic [7:0] tx_byte,
    output logic       reset_req,
    output logic       streaming,
    output logic [7:0] dropped
);

    localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_ARG    = 2'd2;
    localparam logic [1:0] ST_BURST  = 2'd3;
    localparam logic [1:0] ST_RESET  = DEFAULT_RUN ? ST_STREAM : ST_IDLE;

    localparam logic [7:0] CMD_GO     = 8'h67;
    localparam logic [7:0] CMD_HALT   = 8'h68;
    localparam logic [7:0] CMD_BURST  = 8'h62;
    localparam logic [7:0] CMD_RESET  = 8'h72;

    logic [1:0]    state, state_next;
    logic [8:0]    remaining, remaining_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic running, cmd_valid, flush, fifo_empty, fifo_full;
    logic send_go, pop, word_in, push, drop;
    logic status_pend;
    logic [7:0] send_byte;

    assign running    = (state == ST_STREAM) || (state == ST_BURST);
    assign streaming  = running;
    assign cmd_valid  = rx_received && (state != ST_ARG);
    assign flush      = cmd_valid && (rx_byte == CMD_RESET);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);

    // A pending status byte takes the send slot without popping the FIFO.
    assign send_go = tx_free && !transmit && !flush && (!fifo_empty || status_pend);
    assign pop     = send_go && !status_pend;
    assign word_in = word_valid && running;
    assign push    = word_in && (!fifo_full || pop);
    assign drop    = word_in && fifo_full && !pop;

`ifdef RNG_STREAM_STATUS_EN
    localparam logic [7:0] CMD_STATUS = 8'h73;

    logic [7:0] status_byte;
    logic [3:0] occ4;
    logic       status_cmd;

    assign occ4       = 4'(count);
    assign status_cmd = cmd_valid && (rx_byte == CMD_STATUS);
    assign send_byte  = status_pend ? status_byte : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_pend <= 1'b0;
            status_byte <= '0;
        end else if (flush) begin
            status_pend <= 1'b0;
        end else if (status_cmd) begin
            status_pend <= 1'b1;
            status_byte <= {running, state == ST_BURST, fifo_full, dropped != '0, occ4};
        end else if (send_go) begin
            status_pend <= 1'b0;
        end
    end
`else
    assign status_pend = 1'b0;
    assign send_byte   = mem[rd_ptr];
`endif

    // Command decode overrides a same-edge burst completion.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        if (push && (state == ST_BURST)) begin
            remaining_next = remaining - 9'd1;
            if (remaining == 9'd1) state_next = ST_IDLE;
        end
        if (rx_received) begin
            if (state == ST_ARG) begin
                remaining_next = {1'b0, rx_byte} + 9'd1;
                state_next     = ST_BURST;
            end else begin
                case (rx_byte)
                    CMD_GO:    state_next = ST_STREAM;
                    CMD_HALT:  state_next = ST_IDLE;
                    CMD_BURST: state_next = ST_ARG;
                    CMD_RESET: begin
                        state_next     = ST_IDLE;
                        remaining_next = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RESET;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped <= '0;
        end else if (flush) begin
            dropped <= '0;
        end else if (drop && (dropped != 8'hFF)) begin
            dropped <= dropped + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            transmit  <= 1'b0;
            tx_byte   <= '0;
            reset_req <= 1'b0;
        end else begin
            transmit  <= send_go;
            reset_req <= flush;
            if (send_go) tx_byte <= send_byte;
        end
    end

endmodule

// File: doc/rng_stream_ctrl.md
# rng_stream_ctrl

Command-driven scheduler between the randomized LFSR word source and the UART transmitter. It decodes single-byte host commands from the UART receiver and buffers accepted random words in a small FIFO. It paces `transmit` pulses against `tx_free` and counts words dropped on overflow. It replaces the free-running "transmit on every word strobe" hookup, so the host can start, stop, or request fixed-length bursts of entropy.

## Interface
- `FIFO_DEPTH`, 4: word buffer entries; power of two, 2..16.
- `DEFAULT_RUN`, 0: 1 = enter STREAM after reset; 0 = enter IDLE.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `word_valid` in 1: one-cycle strobe; a new random word is available.
- `word` in 8: random byte, sampled when `word_valid` = 1.
- `rx_received` in 1: one-cycle strobe; a host byte has been received.
- `rx_byte` in 8: received byte, sampled when `rx_received` = 1.
- `tx_free` in 1: transmitter idle, can accept a byte.
- `transmit` out 1: one-cycle request to send `tx_byte`.
- `tx_byte` out 8: byte to send; valid in the cycle `transmit` = 1.
- `reset_req` out 1: one-cycle pulse to the system reset timer.
- `streaming` out 1: 1 in STREAM or BURST.
- `dropped` out 8: count of words lost to a full FIFO; saturates at 255.

## Operation
- States:
  - IDLE: words ignored.
  - STREAM: accept every word.
  - ARG: wait for the burst length byte.
  - BURST: accept words until `remaining` = 0.
- Commands, decoded in IDLE/STREAM/BURST; every other byte is ignored:
  - 0x67 'g' → STREAM.
  - 0x68 'h' → IDLE. The FIFO still drains.
  - 0x62 'b' → ARG.
  - 0x72 'r' → IDLE. Pulse `reset_req`, flush the FIFO, clear `dropped` and `remaining`.
- ARG: the next received byte N is always the argument, including 0x72. Load `remaining` = N+1 (9 bits, 1..256) and go to BURST.
- BURST: each pushed word decrements `remaining`. When the decrement reaches 0, go to IDLE in the same edge. Dropped words do not decrement.
- Push: `word_valid` in STREAM/BURST while (not full, or pop in the same cycle).
  - If the FIFO is full and there is no pop, the word is dropped and `dropped` increments, saturating.
  - Words arriving in IDLE/ARG are neither pushed nor counted.
- Pop/send condition: FIFO non-empty, `tx_free` = 1, and `transmit` was 0 in the previous cycle (one-cycle holdoff so the UART can deassert `tx_free`).
- On send: `transmit` = 1 and `tx_byte` = FIFO head, both registered. The head is removed on the same edge.
- A command and `word_valid` in the same cycle: the word is evaluated under the state before the command.
- Pointers wrap modulo `FIFO_DEPTH`. The occupancy counter is log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values:
  - `transmit` = 0, `tx_byte` = 0x00, `reset_req` = 0, `dropped` = 0.
  - FIFO empty, `remaining` = 0.
  - `streaming` = `DEFAULT_RUN`.
- Word-to-transmit latency, FIFO empty and `tx_free` = 1: `transmit` rises 1 cycle after the `word_valid` edge (push edge, then pop edge).
- Back-to-back sends are at least 2 cycles apart. In practice the spacing is set by `tx_free`.
- Command effect: state and `streaming` update on the edge that samples `rx_received`. `reset_req` is high during the following cycle only.
- `rst_n` asserted mid-burst or mid-send aborts immediately. No partial `transmit` is held.

## Configuration
- `RNG_STREAM_STATUS_EN` defined:
  - Command 0x73 's' queues one status byte {`streaming`, state==BURST, fifo_full, `dropped`!=0, occupancy[3:0]}, captured when the command is received.
  - The status byte is sent at the next send opportunity, ahead of the FIFO head, and does not pop the FIFO.
  - A second 's' before that send overwrites the pending status byte.
- `RNG_STREAM_STATUS_EN` undefined: 0x73 is ignored, and no status logic is synthesized.

## Test plan
- Reset with `DEFAULT_RUN`=0, then 3 `word_valid` strobes (0x11, 0x22, 0x33) with `tx_free`=1 → no `transmit`, `streaming`=0, `dropped`=0.
- 'g', then words 0xA5, 0x5A, `tx_free` toggled by a UART model → `transmit` twice with `tx_byte` 0xA5 then 0x5A, ≥2 cycles apart.
- 'b' then 0x02, then 5 words with `tx_free`=1 → exactly 3 bytes sent, state IDLE after the third push, `streaming`=0.
- 'g' with `tx_free` held 0 and `FIFO_DEPTH`=4, then 7 words → 4 buffered, `dropped`=3. Release `tx_free` → the 4 oldest are sent in order.
- In STREAM with 2 words buffered, send 'r' → `reset_req` high for 1 cycle, FIFO empty, `dropped`=0, no further `transmit`.
- With `RNG_STREAM_STATUS_EN`: in STREAM with 2 buffered words and `tx_free`=0, send 's', then set `tx_free`=1 → first byte 0x82, then the 2 words.
